// File: rtl/bounce_generator.sv
// Bouncy contact emulator: turns clean level changes into a burst of chatter followed by a settle window.
// Define BOUNCE_RANDOM_EN to take bounce values from a 16-bit LFSR instead of an alternating pattern.
//   state  | meaning
//   IDLE   | bounce_out holds stable_level, watching level_q for a change
//   BOUNCE | one bounce value per cycle for BOUNCE_CYCLES cycles
//   SETTLE | bounce_out = target for SETTLE_CYCLES cycles, done on the last
module bounce_generator #(
    parameter int unsigned BOUNCE_CYCLES = 12,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [7:0]  BC_LOAD  = 8'(BOUNCE_CYCLES - 1);
    localparam logic [7:0]  SC_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_t      r_state, w_next_state;
    logic [7:0]  r_cnt, w_next_cnt;
    logic [15:0] r_lfsr, w_lfsr_next;
    logic        r_level_q;
    logic        r_stable, w_next_stable;
    logic        r_target, w_next_target;
    logic        r_bounce_out, w_bounce_val;
    logic        r_busy, w_busy_val;
    logic        r_done, w_done_val;
    logic        w_bounce_bit;

    // Taps 16,14,13,11 in Fibonacci form, shifting toward bit 0.
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

`ifdef BOUNCE_RANDOM_EN
    // Registered so that bounce_out equals the LFSR bit 0 visible in the same cycle.
    assign w_bounce_bit = w_lfsr_next[0];
`else
    // Bounce index = BC_LOAD - cnt, so its parity is BC_LOAD[0] ^ cnt[0]; index 0 carries target.
    assign w_bounce_bit = r_target ^ BC_LOAD[0] ^ r_cnt[0];
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_stable = r_stable;
        w_next_target = r_target;
        w_bounce_val  = r_stable;
        w_busy_val    = 1'b0;
        w_done_val    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level_q != r_stable) begin
                    w_next_target = r_level_q;
                    w_next_cnt    = BC_LOAD;
                    w_next_state  = S_BOUNCE;
                end
            end
            S_BOUNCE: begin
                w_busy_val   = 1'b1;
                w_bounce_val = w_bounce_bit;
                if (r_cnt == 8'd0) begin
                    w_next_cnt   = SC_LOAD;
                    w_next_state = S_SETTLE;
                end else begin
                    w_next_cnt = r_cnt - 8'd1;
                end
            end
            S_SETTLE: begin
                w_busy_val   = 1'b1;
                w_bounce_val = r_target;
                if (r_cnt == 8'd0) begin
                    w_next_stable = r_target;
                    w_done_val    = 1'b1;
                    w_next_state  = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 8'd1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_lfsr       <= SEED_EFF;
            r_level_q    <= 1'b0;
            r_stable     <= 1'b0;
            r_target     <= 1'b0;
            r_bounce_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_lfsr       <= w_lfsr_next;
            r_level_q    <= level_in;
            r_stable     <= w_next_stable;
            r_target     <= w_next_target;
            r_bounce_out <= w_bounce_val;
            r_busy       <= w_busy_val;
            r_done       <= w_done_val;
        end
    end

    assign bounce_out = r_bounce_out;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: directed scenarios plus random level traffic against a burst-schedule model.
module tb_bounce_generator;

    localparam int          BC   = 4;
    localparam int          SC   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic level_in = 1'b0;
    logic bounce_out, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a schedule of upcoming busy cycles (>=0 bounce index, -1 settle, -2 last settle).
    int          sched[$];
    logic        m_stable, m_target, m_lq;
    logic [15:0] m_lfsr;

    logic prev_busy = 1'b0;
    int   n_rise = 0;
    int   n_done = 0;

    bounce_generator #(
        .BOUNCE_CYCLES(BC),
        .SETTLE_CYCLES(SC),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_in  (level_in),
        .bounce_out(bounce_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        m_stable  = 1'b0;
        m_target  = 1'b0;
        m_lq      = 1'b0;
        m_lfsr    = SEED;
        prev_busy = 1'b0;
    endtask

    task automatic step(input logic lv);
        logic prev_lq, e_b, e_busy, e_done;
        int   k;
        level_in = lv;
        @(posedge clk);
        cyc++;
        prev_lq = m_lq;
        m_lq    = lv;
        m_lfsr  = lfsr_adv(m_lfsr);
        if (sched.size() == 0) begin
            e_b    = m_stable;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (prev_lq != m_stable) begin
                m_target = prev_lq;
                for (int i = 0; i < BC; i++) sched.push_back(i);
                for (int j = 0; j < SC - 1; j++) sched.push_back(-1);
                sched.push_back(-2);
            end
        end else begin
            k      = sched.pop_front();
            e_busy = 1'b1;
            e_done = (k == -2);
            if (k >= 0) begin
`ifdef BOUNCE_RANDOM_EN
                e_b = m_lfsr[0];
`else
                e_b = m_target ^ k[0];
`endif
            end else begin
                e_b = m_target;
            end
            if (k == -2) m_stable = m_target;
        end
        @(negedge clk);
        check("bounce_out", bounce_out, e_b);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (busy && !prev_busy) n_rise++;
        prev_busy = busy;
        if (done) n_done++;
    endtask

    // Drives a constant level for n cycles and records the busy-window values and pulse counts.
    task automatic run_window(input logic lv, input int n, output logic [6:0] seq,
                              output int nbusy, output int ndone, output logic done_last);
        seq = '0; nbusy = 0; ndone = 0; done_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(lv);
            if (busy) begin
                seq = {seq[5:0], bounce_out};
                nbusy++;
                done_last = done;
            end
            if (done) ndone++;
        end
    endtask

    logic [6:0] seq;
    int         nb, nd;
    logic       dl;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bounce_out", bounce_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0);

        // Rising edge burst.
        run_window(1'b1, 12, seq, nb, nd, dl);
`ifndef BOUNCE_RANDOM_EN
        check("rise_seq_b6", seq[6], 1'b1);
        check("rise_seq_b5", seq[5], 1'b0);
        check("rise_seq_b4", seq[4], 1'b1);
        check("rise_seq_b3", seq[3], 1'b0);
        check("rise_seq_tail", (seq[2:0] == 3'b111), 1'b1);
`endif
        check("rise_busy7", (nb == 7), 1'b1);
        check("rise_done1", (nd == 1), 1'b1);
        check("rise_done_last", dl, 1'b1);
        check("rise_stable", bounce_out, 1'b1);

        // Falling edge burst.
        run_window(1'b0, 12, seq, nb, nd, dl);
`ifndef BOUNCE_RANDOM_EN
        check("fall_seq_head", (seq[6:3] == 4'b0101), 1'b1);
        check("fall_seq_tail", (seq[2:0] == 3'b000), 1'b1);
`endif
        check("fall_busy7", (nb == 7), 1'b1);
        check("fall_done1", (nd == 1), 1'b1);
        check("fall_stable", bounce_out, 1'b0);

        // Short pulse during BOUNCE: one burst up, then one burst back down.
        n_rise = 0; n_done = 0;
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 22; i++) step(1'b0);
        check("pulse_bursts2", (n_rise == 2), 1'b1);
        check("pulse_done2", (n_done == 2), 1'b1);
        check("pulse_final", bounce_out, 1'b0);

        // Toggle and return during SETTLE: no extra burst.
        n_rise = 0; n_done = 0;
        for (int i = 0; i < 6; i++) step(1'b1);
        step(1'b0);
        for (int i = 0; i < 13; i++) step(1'b1);
        check("settle_bursts1", (n_rise == 1), 1'b1);
        check("settle_done1", (n_done == 1), 1'b1);
        check("settle_final", bounce_out, 1'b1);

        // Randomized level traffic.
        begin
            logic lv;
            lv = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0) lv = ~lv;
                step(lv);
            end
        end

        // Reset in the middle of a burst.
        for (int i = 0; i < 12; i++) step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bounce_out", bounce_out, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            check("hold_rst_done", done, 1'b0);
            check("hold_rst_busy", busy, 1'b0);
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) step(1'b1);
        check("post_rst_done1", (n_done == 1), 1'b1);
        check("post_rst_stable", bounce_out, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
